// File: rtl/u2_serial_adder.sv
// Purpose : bit-serial two's-complement adder/subtractor, LSB-first, one full adder + carry flop.
// Latency : WIDTH cycles from accepted start to done; one result per WIDTH+1 cycles back-to-back.
// Backpressure: none; start is only honoured in IDLE, a start during ADD is dropped (not queued).
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start, sub      operation request (sampled in IDLE only); sub=1 selects a-b
//   a, b            WIDTH-bit U2 operands, latched on the accepting edge
//   sum, ovf        registered result and signed overflow, held until the next completion
//   busy, done      operation in progress / one-cycle result-valid pulse
//
// Build option: define U2_SERIAL_ADDER_SAT_EN to saturate sum on overflow instead of wrapping.
module u2_serial_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ADD  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Single full adder on the current LSBs of the shifting operand registers.
  logic bit_s;
  logic bit_cout;
  assign bit_s    = a_q[0] ^ b_q[0] ^ carry_q;
  assign bit_cout = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        res_d   = {bit_s, res_q[WIDTH-1:1]};
        carry_d = bit_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // On the MSB step carry_q is the carry into the MSB, bit_cout the carry out.
          ovf_d   = carry_q ^ bit_cout;
          sum_d   = res_d;
`ifdef U2_SERIAL_ADDER_SAT_EN
          // a_q[0] holds the original A sign bit here; overflow direction follows it.
          if (carry_q ^ bit_cout) begin
            sum_d = a_q[0] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
          end
`endif
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sum  = sum_q;
  assign ovf  = ovf_q;
  assign busy = (state_q == ADD);
  assign done = done_q;

endmodule
